wu_decode: RTL and testbench
============================

Name: wu_decode

Overview:
- Downstream neighbour of the WU fetch stage.
- Consumes the instruction words the WU memory returns for the fetch stage's read addresses, and buffers them in a small FIFO.
- Assembles each descriptor (header, option tuples, end marker) into one decoded transaction for the manager's downstream controllers.
- Asserts the stall that throttles the fetch stage.

Parameters:
- WU_WIDTH, 32, WU memory word width.
- FIFO_DEPTH, 8, input buffer entries (power of 2).
- STALL_MARGIN, 3, free entries reserved for words already in flight when stall asserts.
- MAX_OPTS, 4, option slots per decoded descriptor.

Ports:
- clk  in  1  clock
- reset_poweron  in  1  reset
- wum__wud__valid  in  1  read data valid from WU memory
- wum__wud__data  in  WU_WIDTH  instruction word
- wud__wuf__stall  out  1  stall to fetch stage
- wud__dst__valid  out  1  decoded descriptor valid
- dst__wud__ready  in  1  downstream accepts descriptor
- wud__dst__opcode  out  4  descriptor opcode
- wud__dst__tag  out  16  descriptor tag
- wud__dst__opt_mask  out  MAX_OPTS  slot i holds a valid option
- wud__dst__opt_type  out  4*MAX_OPTS  option types, slot 0 in LSBs
- wud__dst__opt_value  out  24*MAX_OPTS  option values, slot 0 in LSBs
- wud__err  out  1  sticky decode/overflow error
- mcntl__wud__err_clear  in  1  clears wud__err

Interface:
- Single clock clk.
- reset_poweron is synchronous, active-high.
- All outputs are registered.

Behaviour:

Word format:
- [31:30] kind: 00 NOP, 01 SOD, 10 OPT, 11 EOD.
- SOD: [29:26] opcode, [15:0] tag.
- OPT: [29:26] option type, [23:0] value.
- EOD and NOP: remaining fields ignored.

Reset:
- All outputs 0.
- FIFO empty, state IDLE, option count 0.

FIFO:
- Push when wum__wud__valid is 1.
- Pop when not empty and state != EMIT.
- Push and pop in the same cycle: count unchanged.
- Push while full and no pop: word dropped, wud__err set.

Stall:
- wud__wuf__stall is registered: 1 the cycle after count >= FIFO_DEPTH-STALL_MARGIN, else 0.

State machine (one popped word per cycle):
- IDLE:
  - SOD: latch opcode and tag, clear mask and slot index, go to COLLECT.
  - NOP: ignored.
  - OPT or EOD: discarded, set wud__err, stay in IDLE.
- COLLECT:
  - OPT with index < MAX_OPTS: write the slot, set its mask bit, increment index.
  - OPT with index = MAX_OPTS: discarded, set wud__err.
  - NOP: ignored.
  - SOD: set wud__err, restart the descriptor with the new opcode and tag (old descriptor abandoned).
  - EOD: load output registers, go to EMIT.
- EMIT:
  - wud__dst__valid is 1 from the cycle after the EOD pop.
  - Payload is held stable until dst__wud__ready is 1.
  - On that cycle go to IDLE; valid drops the next cycle.
  - Minimum descriptor period is therefore SOD + n OPT + EOD + 1 cycle.
- An EOD with zero options is legal and emits mask 0.

Error:
- wud__err is set on any error event.
- Cleared by mcntl__wud__err_clear.
- If set and clear occur in the same cycle, set wins.

Reset mid-operation:
- FIFO flushed.
- Any partial or pending descriptor discarded with no emit.
- Stall deasserts the next cycle.

Test Plan:
1. Push SOD(op=3, tag=0x0012), OPT(type=1, val=0x000100), OPT(type=2, val=0x0000FF), EOD with ready held at 1 -> exactly one valid pulse, 1 cycle; opcode=3, tag=0x0012, mask=0011, slot0=(1,0x000100), slot1=(2,0x0000FF); wud__err=0.
2. Same descriptor with ready=0 for 10 cycles while 6 more words push -> payload stable throughout; stall rises once count>=5; no word lost; next descriptor emits after ready.
3. SOD, then 5 OPTs, then EOD -> mask=1111, slots hold the first 4 options, wud__err=1; mcntl__wud__err_clear pulse -> wud__err=0.
4. OPT arriving in IDLE, followed by SOD(op=7), EOD -> OPT discarded, wud__err=1, one emit with opcode=7, mask=0000.
5. Continuous valid for 12 cycles with ready=0, ignoring stall -> FIFO fills at 8 entries, overflow sets wud__err, count never exceeds 8.
6. Assert reset_poweron for 1 cycle mid-COLLECT -> all outputs 0 next cycle, no emit of the partial descriptor; a fresh SOD/EOD then decodes normally.

Source files
------------

// File: rtl/wu_decode.sv
// WU decode stage: buffers instruction words returned for the fetch stage and
// assembles SOD/OPT/EOD sequences into one decoded descriptor per emit.
module wu_decode #(
    parameter int unsigned WU_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STALL_MARGIN = 3,
    parameter int unsigned MAX_OPTS     = 4
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     wum__wud__valid,
    input  logic [WU_WIDTH-1:0]      wum__wud__data,
    output logic                     wud__wuf__stall,
    output logic                     wud__dst__valid,
    input  logic                     dst__wud__ready,
    output logic [3:0]               wud__dst__opcode,
    output logic [15:0]              wud__dst__tag,
    output logic [MAX_OPTS-1:0]      wud__dst__opt_mask,
    output logic [4*MAX_OPTS-1:0]    wud__dst__opt_type,
    output logic [24*MAX_OPTS-1:0]   wud__dst__opt_value,
    output logic                     wud__err,
    input  logic                     mcntl__wud__err_clear
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(MAX_OPTS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NOP = 2'b00,
        K_SOD = 2'b01,
        K_OPT = 2'b10,
        K_EOD = 2'b11
    } kind_t;

    logic [WU_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_stall;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [3:0]            r_cur_op;
    logic [15:0]           r_cur_tag;
    logic [MAX_OPTS-1:0]   r_cur_mask;
    logic [4*MAX_OPTS-1:0] r_cur_type;
    logic [24*MAX_OPTS-1:0] r_cur_val;
    logic [IW-1:0]         r_idx;

    logic                  r_valid;
    logic [3:0]            r_op;
    logic [15:0]           r_tag;
    logic [MAX_OPTS-1:0]   r_mask;
    logic [4*MAX_OPTS-1:0] r_type;
    logic [24*MAX_OPTS-1:0] r_val;
    logic                  r_err;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf;
    logic [WU_WIDTH-1:0]   w_word;
    kind_t                 w_kind;
    logic                  w_latch_hdr;
    logic                  w_write_opt;
    logic                  w_load_out;
    logic                  w_release;
    logic                  w_dec_err;
    logic                  w_err_set;
    logic                  w_unused;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_pop    = !w_empty && (r_state != S_EMIT);
    // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
    assign w_push   = wum__wud__valid && (!w_full || w_pop);
    assign w_ovf    = wum__wud__valid && w_full && !w_pop;
    assign w_word   = r_mem[r_rd_ptr];
    assign w_kind   = kind_t'(w_word[31:30]);
    assign w_unused = ^w_word[25:24];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wum__wud__data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            r_stall <= (r_count >= CW'(FIFO_DEPTH - STALL_MARGIN));
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_pop && w_kind == K_SOD) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_pop && w_kind == K_EOD) w_state_nxt = S_EMIT;
            S_EMIT:    if (dst__wud__ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch_hdr = 1'b0;
        w_write_opt = 1'b0;
        w_load_out  = 1'b0;
        w_release   = 1'b0;
        w_dec_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    case (w_kind)
                        K_SOD:   w_latch_hdr = 1'b1;
                        K_OPT,
                        K_EOD:   w_dec_err   = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_COLLECT: begin
                if (w_pop) begin
                    case (w_kind)
                        K_SOD: begin
                            w_latch_hdr = 1'b1;
                            w_dec_err   = 1'b1;
                        end
                        K_OPT: begin
                            if (r_idx < IW'(MAX_OPTS)) w_write_opt = 1'b1;
                            else                       w_dec_err   = 1'b1;
                        end
                        K_EOD:   w_load_out = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_EMIT:  w_release = dst__wud__ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_cur_op   <= '0;
            r_cur_tag  <= '0;
            r_cur_mask <= '0;
            r_cur_type <= '0;
            r_cur_val  <= '0;
            r_idx      <= '0;
        end else if (w_latch_hdr) begin
            r_cur_op   <= w_word[29:26];
            r_cur_tag  <= w_word[15:0];
            r_cur_mask <= '0;
            r_cur_type <= '0;
            r_cur_val  <= '0;
            r_idx      <= '0;
        end else if (w_write_opt) begin
            for (int unsigned s = 0; s < MAX_OPTS; s++) begin
                if (r_idx == IW'(s)) begin
                    r_cur_mask[s]          <= 1'b1;
                    r_cur_type[s*4 +: 4]   <= w_word[29:26];
                    r_cur_val[s*24 +: 24]  <= w_word[23:0];
                end
            end
            r_idx <= r_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_tag   <= '0;
            r_mask  <= '0;
            r_type  <= '0;
            r_val   <= '0;
        end else if (w_load_out) begin
            r_valid <= 1'b1;
            r_op    <= r_cur_op;
            r_tag   <= r_cur_tag;
            r_mask  <= r_cur_mask;
            r_type  <= r_cur_type;
            r_val   <= r_cur_val;
        end else if (w_release) begin
            r_valid <= 1'b0;
        end
    end

    assign w_err_set = w_ovf || w_dec_err;

    always_ff @(posedge clk) begin
        if (reset_poweron)              r_err <= 1'b0;
        else if (w_err_set)             r_err <= 1'b1;
        else if (mcntl__wud__err_clear) r_err <= 1'b0;
    end

    assign wud__wuf__stall     = r_stall;
    assign wud__dst__valid     = r_valid;
    assign wud__dst__opcode    = r_op;
    assign wud__dst__tag       = r_tag;
    assign wud__dst__opt_mask  = r_mask;
    assign wud__dst__opt_type  = r_type;
    assign wud__dst__opt_value = r_val;
    assign wud__err            = r_err;

endmodule

// File: tb/tb_wu_decode.sv
// Bench for wu_decode: queue-based descriptor model checked every cycle, plus
// directed descriptor sequences with hand-computed payloads.
module tb_wu_decode;

    localparam int D = 8;
    localparam int M = 3;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic        stall;
    logic        ovalid;
    logic        rdy;
    logic [3:0]  op;
    logic [15:0] tag;
    logic [3:0]  mask;
    logic [15:0] otype;
    logic [95:0] oval;
    logic        err;
    logic        clr;

    always #5 clk = ~clk;

    wu_decode #(
        .WU_WIDTH(32),
        .FIFO_DEPTH(D),
        .STALL_MARGIN(M),
        .MAX_OPTS(N)
    ) dut (
        .clk(clk),
        .reset_poweron(rst),
        .wum__wud__valid(vld),
        .wum__wud__data(data),
        .wud__wuf__stall(stall),
        .wud__dst__valid(ovalid),
        .dst__wud__ready(rdy),
        .wud__dst__opcode(op),
        .wud__dst__tag(tag),
        .wud__dst__opt_mask(mask),
        .wud__dst__opt_type(otype),
        .wud__dst__opt_value(oval),
        .wud__err(err),
        .mcntl__wud__err_clear(clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sod(input logic [3:0] o, input logic [15:0] t);
        return {2'b01, o, 10'b0, t};
    endfunction
    function automatic logic [31:0] opt(input logic [3:0] ty, input logic [23:0] v);
        return {2'b10, ty, 2'b00, v};
    endfunction
    function automatic logic [31:0] eod();
        return {2'b11, 30'b0};
    endfunction

    // Model state: pending words, the descriptor under construction, expected outputs.
    logic [31:0] q[$];
    bit          m_live = 0;
    bit          m_in_desc;
    logic [3:0]  m_op;
    logic [15:0] m_tag;
    int          m_n;
    logic [3:0]  m_types [N];
    logic [23:0] m_vals  [N];
    logic        e_valid, e_stall, e_err;
    logic [3:0]  e_op;
    logic [15:0] e_tag;
    logic [3:0]  e_mask;
    logic [15:0] e_type;
    logic [95:0] e_val;

    task automatic model_step();
        bit          can_pop;
        bit          es;
        logic [31:0] w;
        if (rst) begin
            q.delete();
            m_in_desc = 0; m_n = 0; m_op = '0; m_tag = '0;
            for (int i = 0; i < N; i++) begin m_types[i] = '0; m_vals[i] = '0; end
            e_valid = 0; e_stall = 0; e_err = 0;
            e_op = '0; e_tag = '0; e_mask = '0; e_type = '0; e_val = '0;
            m_live = 1;
            return;
        end
        es = 0;
        e_stall = (q.size() >= D - M);
        can_pop = (q.size() > 0) && !e_valid;
        if (e_valid && rdy) e_valid = 0;
        if (can_pop) begin
            w = q.pop_front();
            case (w[31:30])
                2'b01: begin
                    if (m_in_desc) es = 1;
                    m_in_desc = 1; m_op = w[29:26]; m_tag = w[15:0]; m_n = 0;
                    for (int i = 0; i < N; i++) begin m_types[i] = '0; m_vals[i] = '0; end
                end
                2'b10: begin
                    if (!m_in_desc || m_n >= N) es = 1;
                    else begin
                        m_types[m_n] = w[29:26]; m_vals[m_n] = w[23:0]; m_n++;
                    end
                end
                2'b11: begin
                    if (!m_in_desc) es = 1;
                    else begin
                        e_valid = 1; e_op = m_op; e_tag = m_tag;
                        e_mask = 4'((1 << m_n) - 1);
                        for (int i = 0; i < N; i++) begin
                            e_type[i*4 +: 4]  = m_types[i];
                            e_val[i*24 +: 24] = m_vals[i];
                        end
                        m_in_desc = 0;
                    end
                end
                default: ;
            endcase
        end
        if (vld) begin
            if (q.size() < D) q.push_back(data);
            else es = 1;
        end
        if (es) e_err = 1;
        else if (clr) e_err = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("valid", ovalid, e_valid);
            chk("stall", stall, e_stall);
            chk("err", err, e_err);
            if (e_valid) begin
                chk("opcode", op, e_op);
                chk("tag", tag, e_tag);
                chk("mask", mask, e_mask);
                chk("opt_type", otype, e_type);
                chk("opt_value", oval, e_val);
            end
            if (ovalid === 1'b1) n_pulses++;
        end
    end

    task automatic step(input logic v, input logic [31:0] d);
        vld = v; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ovalid === 1'b1) break;
        end
        chk({name, "_timeout"}, ovalid, 1'b1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, ovalid, 1'b0);
        chk({name, "_stall"}, stall, 1'b0);
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_op"}, op, 4'h0);
        chk({name, "_tag"}, tag, 16'h0);
        chk({name, "_mask"}, mask, 4'h0);
        chk({name, "_type"}, otype, 16'h0);
        chk({name, "_val"}, oval, 96'h0);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1; vld = 1'b0; data = '0; rdy = 1'b0; clr = 1'b0;
        step(0, 0); step(0, 0);
        rst = 1'b0;
        check_zero("reset");

        // basic descriptor, ready held high
        rdy = 1'b1;
        p0 = n_pulses;
        step(1, sod(4'd3, 16'h0012));
        step(1, opt(4'd1, 24'h000100));
        step(1, opt(4'd2, 24'h0000FF));
        step(1, eod());
        vld = 1'b0;
        wait_valid("t1");
        chk("t1_op", op, 4'd3);
        chk("t1_tag", tag, 16'h0012);
        chk("t1_mask", mask, 4'b0011);
        chk("t1_type", otype, 16'h0021);
        chk("t1_val", oval, {24'h0, 24'h0, 24'h0000FF, 24'h000100});
        chk("t1_err", err, 1'b0);
        repeat (4) step(0, 0);
        chk("t1_pulses", n_pulses - p0, 1);

        // backpressure with words still arriving
        rdy = 1'b0;
        step(1, sod(4'd3, 16'h0012));
        step(1, opt(4'd1, 24'h000100));
        step(1, opt(4'd2, 24'h0000FF));
        step(1, eod());
        step(1, sod(4'd5, 16'h0034));
        step(1, opt(4'd3, 24'hABCDEF));
        step(1, eod());
        step(1, 32'h0);
        step(1, 32'h0);
        step(1, 32'h0);
        vld = 1'b0;
        repeat (3) step(0, 0);
        chk("t2_stall", stall, 1'b1);
        chk("t2_held_valid", ovalid, 1'b1);
        chk("t2_held_op", op, 4'd3);
        rdy = 1'b1;
        step(0, 0);
        wait_valid("t2b");
        chk("t2b_op", op, 4'd5);
        chk("t2b_tag", tag, 16'h0034);
        chk("t2b_mask", mask, 4'b0001);
        chk("t2b_type", otype, 16'h0003);
        chk("t2b_val", oval, 96'h00ABCDEF);
        repeat (6) step(0, 0);
        chk("t2_stall_drop", stall, 1'b0);

        // option overflow
        step(1, sod(4'd1, 16'h0101));
        step(1, opt(4'd1, 24'h000011));
        step(1, opt(4'd2, 24'h000022));
        step(1, opt(4'd3, 24'h000033));
        step(1, opt(4'd4, 24'h000044));
        step(1, opt(4'd5, 24'h000055));
        step(1, eod());
        vld = 1'b0;
        wait_valid("t3");
        chk("t3_op", op, 4'd1);
        chk("t3_mask", mask, 4'b1111);
        chk("t3_type", otype, 16'h4321);
        chk("t3_val", oval, {24'h000044, 24'h000033, 24'h000022, 24'h000011});
        chk("t3_err", err, 1'b1);
        step(0, 0);
        pulse_clear();
        chk("t3_err_clr", err, 1'b0);

        // stray OPT in idle, then empty descriptor
        step(1, opt(4'd1, 24'h000001));
        step(1, sod(4'd7, 16'h0077));
        step(1, eod());
        vld = 1'b0;
        wait_valid("t4");
        chk("t4_op", op, 4'd7);
        chk("t4_tag", tag, 16'h0077);
        chk("t4_mask", mask, 4'b0000);
        chk("t4_err", err, 1'b1);
        repeat (2) step(0, 0);
        pulse_clear();

        // FIFO overflow: 12 consecutive words, ready low
        rdy = 1'b0;
        step(1, sod(4'd2, 16'h0002));
        step(1, eod());
        step(1, sod(4'd9, 16'h0099));
        step(1, opt(4'd1, 24'h000011));
        repeat (5) step(1, 32'h0);
        step(1, eod());
        step(1, opt(4'd2, 24'h000022));
        step(1, eod());
        vld = 1'b0;
        step(0, 0);
        chk("t5_err", err, 1'b1);
        chk("t5_stall", stall, 1'b1);
        rdy = 1'b1;
        step(0, 0);
        p0 = n_pulses;
        wait_valid("t5");
        chk("t5_op", op, 4'd9);
        chk("t5_tag", tag, 16'h0099);
        chk("t5_mask", mask, 4'b0001);
        repeat (8) step(0, 0);
        chk("t5_pulses", n_pulses - p0, 1);
        pulse_clear();

        // reset while collecting
        step(1, sod(4'd4, 16'h0004));
        step(1, opt(4'd1, 24'h000001));
        vld = 1'b0;
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        check_zero("t6_reset");
        p0 = n_pulses;
        repeat (3) step(0, 0);
        chk("t6_no_emit", n_pulses - p0, 0);
        step(1, sod(4'd6, 16'h0066));
        step(1, eod());
        vld = 1'b0;
        wait_valid("t6");
        chk("t6_op", op, 4'd6);
        chk("t6_tag", tag, 16'h0066);
        chk("t6_mask", mask, 4'b0000);
        repeat (3) step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
